// File: rtl/maquinas_pkg.sv
// rtl/maquinas_pkg.sv - shared state encoding and default timing for the machine responder
// Purpose: channel FSM state type and default channel timing constants.
// Ports: none (package).
package maquinas_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_ON    = 3'd3,
    ST_STOP  = 3'd4
  } estado_t;

  localparam int N_MAQ_DEF     = 4;
  localparam int T_PARTIDA_DEF = 8;
  localparam int T_PARADA_DEF  = 4;
  localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/maquina_canal.sv
// rtl/maquina_canal.sv - one machine channel: start/stop FSM with its delay counter
// Purpose: models one machine with a start-up and a stop-down delay.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   cmd        in  run command for this machine
//   grant      in  start permission from the inrush arbiter
//   state      out current FSM state (estado_t encoding)
//   status_nxt out next-state is ON
//   busy_nxt   out next-state is START or STOP
module maquina_canal
  import maquinas_pkg::*;
#(
  parameter int T_PARTIDA = T_PARTIDA_DEF,
  parameter int T_PARADA  = T_PARADA_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd,
  input  logic       grant,
  output logic [2:0] state,
  output logic       status_nxt,
  output logic       busy_nxt
);

  localparam logic [CNT_W-1:0] CNT_PARTIDA = CNT_W'(T_PARTIDA - 1);
  localparam logic [CNT_W-1:0] CNT_PARADA  = CNT_W'(T_PARADA - 1);

  estado_t          st;
  estado_t          st_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= ST_OFF;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      ST_OFF: begin
        if (cmd) st_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!cmd) begin
          st_nxt = ST_OFF;
        end else if (grant) begin
          st_nxt  = ST_START;
          cnt_nxt = CNT_PARTIDA;
        end
      end
      ST_START: begin
        // A dropped command beats a counter reaching zero on the same edge.
        if (!cmd) begin
          st_nxt  = ST_STOP;
          cnt_nxt = CNT_PARADA;
        end else if (cnt == '0) begin
          st_nxt = ST_ON;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_ON: begin
        if (!cmd) begin
          st_nxt  = ST_STOP;
          cnt_nxt = CNT_PARADA;
        end
      end
      ST_STOP: begin
        // Stop-down always runs to completion; a new request waits for OFF.
        if (cnt == '0) begin
          st_nxt = ST_OFF;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        st_nxt  = ST_OFF;
        cnt_nxt = '0;
      end
    endcase
  end

  assign state      = st;
  assign status_nxt = (st_nxt == ST_ON);
  assign busy_nxt   = (st_nxt == ST_START) || (st_nxt == ST_STOP);

endmodule

// File: rtl/maquinas_resposta.sv
// rtl/maquinas_resposta.sv - machine-side responder: N channels, inrush arbiter, registered status
// Purpose: turns per-machine run commands into timed machine status, allowing
//   only one machine to be starting at any time.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   cmd    in  run command per machine (bit0 = c1)
//   status out machine running (ON), registered
//   busy   out channel in START or STOP, registered
//   n_on   out number of machines ON, registered
module maquinas_resposta
  import maquinas_pkg::*;
#(
  parameter int N_MAQ     = N_MAQ_DEF,
  parameter int T_PARTIDA = T_PARTIDA_DEF,
  parameter int T_PARADA  = T_PARADA_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_MAQ-1:0] cmd,
  output logic [N_MAQ-1:0] status,
  output logic [N_MAQ-1:0] busy,
  output logic [2:0]       n_on
);

  logic [2:0]       estado [N_MAQ];
  logic [N_MAQ-1:0] status_nxt;
  logic [N_MAQ-1:0] busy_nxt;
  logic [N_MAQ-1:0] grant;
  logic [N_MAQ-1:0] em_espera;
  logic [N_MAQ-1:0] segura_partida;
  logic [2:0]       n_on_nxt;

  for (genvar i = 0; i < N_MAQ; i++) begin : g_canal
    maquina_canal #(
      .T_PARTIDA (T_PARTIDA),
      .T_PARADA  (T_PARADA),
      .CNT_W     (CNT_W)
    ) u_canal (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd[i]),
      .grant      (grant[i]),
      .state      (estado[i]),
      .status_nxt (status_nxt[i]),
      .busy_nxt   (busy_nxt[i])
    );

    assign em_espera[i] = (estado[i] == ST_WAIT);
    // A starting channel blocks the arbiter only if it is still START after
    // this edge; one finishing its start-up lets the next channel in on the
    // same edge, so back-to-back starts are spaced exactly T_PARTIDA apart.
    assign segura_partida[i] = (estado[i] == ST_START) && cmd[i] && !status_nxt[i];
  end

  always_comb begin
    logic achou;
    grant = '0;
    achou = 1'b0;
    if (segura_partida == '0) begin
      for (int i = 0; i < N_MAQ; i++) begin
        if (em_espera[i] && !achou) begin
          grant[i] = 1'b1;
          achou    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    n_on_nxt = '0;
    for (int i = 0; i < N_MAQ; i++) begin
      n_on_nxt = n_on_nxt + 3'(status_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= '0;
      busy   <= '0;
      n_on   <= '0;
    end else begin
      status <= status_nxt;
      busy   <= busy_nxt;
      n_on   <= n_on_nxt;
    end
  end

endmodule

// File: tb/tb_maquinas_resposta.sv
// tb/tb_maquinas_resposta.sv - directed self-checking bench for maquinas_resposta
module tb_maquinas_resposta;

  logic       clk;
  logic       rst_n;
  logic [3:0] cmd;
  logic [3:0] status;
  logic [3:0] busy;
  logic [2:0] n_on;

  int n_checks = 0;
  int n_errors = 0;

  maquinas_resposta dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd    (cmd),
    .status (status),
    .busy   (busy),
    .n_on   (n_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_status,
                         input logic [3:0] e_busy, input logic [2:0] e_n_on);
    chk({tag, ".status"}, 32'(status), 32'(e_status));
    chk({tag, ".busy"},   32'(busy),   32'(e_busy));
    chk({tag, ".n_on"},   32'(n_on),   32'(e_n_on));
  endtask

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  initial begin
    logic [3:0] e_status;
    logic [3:0] e_busy;

    rst_n = 1'b0;
    cmd   = 4'b0000;
    step(2);
    chk_out("reset_idle", 4'b0000, 4'b0000, 3'd0);

    // 1: reset in the middle of a run, then restart with all requests held.
    rst_n = 1'b1;
    cmd   = 4'b1111;
    step(12);
    chk("pre_reset.status", 32'(status), 32'(4'b0001));
    #3 rst_n = 1'b0;
    #1;
    chk_out("async_reset", 4'b0000, 4'b0000, 3'd0);
    @(posedge clk);
    #1;
    chk_out("reset_held", 4'b0000, 4'b0000, 3'd0);
    rst_n = 1'b1;
    step(1);
    chk_out("rel_k", 4'b0000, 4'b0000, 3'd0);
    step(8);
    chk_out("rel_k8", 4'b0000, 4'b0001, 3'd0);
    step(1);
    chk_out("rel_k9", 4'b0001, 4'b0010, 3'd1);
    cmd = 4'b0000;
    step(8);
    chk_out("rel_idle", 4'b0000, 4'b0000, 3'd0);

    // 2: single start then stop.
    cmd = 4'b0001;
    step(1);
    chk_out("single_k", 4'b0000, 4'b0000, 3'd0);
    step(8);
    chk_out("single_k8", 4'b0000, 4'b0001, 3'd0);
    step(1);
    chk_out("single_k9", 4'b0001, 4'b0000, 3'd1);
    cmd = 4'b0000;
    step(1);
    chk_out("stop_j", 4'b0000, 4'b0001, 3'd0);
    step(3);
    chk_out("stop_j3", 4'b0000, 4'b0001, 3'd0);
    step(1);
    chk_out("stop_j4", 4'b0000, 4'b0000, 3'd0);

    // 2b: command drops on the edge the start counter reaches zero.
    cmd = 4'b0001;
    step(9);
    chk_out("race_k8", 4'b0000, 4'b0001, 3'd0);
    cmd = 4'b0000;
    step(1);
    chk_out("race_k9", 4'b0000, 4'b0001, 3'd0);
    step(3);
    chk_out("race_k12", 4'b0000, 4'b0001, 3'd0);
    step(1);
    chk_out("race_k13", 4'b0000, 4'b0000, 3'd0);

    // 3: all four request on one edge; starts are serialised by index.
    cmd = 4'b1111;
    for (int e = 0; e <= 33; e++) begin
      step(1);
      e_status = '0;
      e_busy   = '0;
      for (int i = 0; i < 4; i++) begin
        if (e >= 9 + 8 * i) e_status[i] = 1'b1;
        if (e >= 1 + 8 * i && e <= 8 + 8 * i) e_busy[i] = 1'b1;
      end
      chk_out($sformatf("contend_e%0d", e), e_status, e_busy, pop4(e_status));
    end

    // 5: ch2 drops and re-requests one edge later.
    cmd = 4'b1011;
    step(1);
    chk_out("rereq_j", 4'b1011, 4'b0100, 3'd3);
    cmd = 4'b1111;
    step(3);
    chk_out("rereq_j3", 4'b1011, 4'b0100, 3'd3);
    step(1);
    chk_out("rereq_j4", 4'b1011, 4'b0000, 3'd3);
    step(1);
    chk_out("rereq_j5", 4'b1011, 4'b0000, 3'd3);
    step(1);
    chk_out("rereq_j6", 4'b1011, 4'b0100, 3'd3);
    step(7);
    chk_out("rereq_j13", 4'b1011, 4'b0100, 3'd3);
    step(1);
    chk_out("rereq_j14", 4'b1111, 4'b0000, 3'd4);

    // 4: ch1 turned off, then a 3-edge request pulse aborts its start.
    cmd = 4'b1101;
    step(5);
    chk_out("abort_off", 4'b1101, 4'b0000, 3'd3);
    cmd = 4'b1111;
    step(1);
    chk_out("abort_e0", 4'b1101, 4'b0000, 3'd3);
    step(1);
    chk_out("abort_e1", 4'b1101, 4'b0010, 3'd3);
    step(1);
    chk_out("abort_e2", 4'b1101, 4'b0010, 3'd3);
    cmd = 4'b1101;
    step(1);
    chk_out("abort_e3", 4'b1101, 4'b0010, 3'd3);
    step(3);
    chk_out("abort_e6", 4'b1101, 4'b0010, 3'd3);
    step(1);
    chk_out("abort_e7", 4'b1101, 4'b0000, 3'd3);

    // 6: open-loop sweep of every command value.
    for (int v = 0; v < 16; v++) begin
      cmd = 4'(v);
      step(40);
      chk_out($sformatf("sweep_%0d", v), 4'(v), 4'b0000, pop4(4'(v)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
